// File: rtl/instr_sequencer.sv
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Multi-cycle instruction sequencer (FETCH/DECODE/EXEC/WB/HALT).
//            It fetches a 16-bit word from instruction memory, decodes it into
//            register-file addresses, ULA controls and a sign-extended
//            immediate, and updates the PC. JMP and a conditional BEQ are
//            supported, as is a sticky halt state.
// Ports    : iCLK, iRST_N            clock, async active-low reset
//            i_run                   allow a new fetch
//            o_imem_addr/req         instruction memory request (addr = PC)
//            i_imem_ack/data         fetch handshake and instruction word
//            o_ra1/o_ra2/o_wa3/o_we3 register-file addresses, write enable
//            o_ula_control/src       ULA operation select, SrcB select
//            o_imm                   sign-extended imm6
//            i_z                     ULA zero flag (sampled at end of EXEC)
//            o_pc, o_state           current PC and state
//            o_halted, o_illegal     sticky status flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        i_run,
  output logic [7:0]  o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_data,
  output logic [2:0]  o_ra1,
  output logic [2:0]  o_ra2,
  output logic [2:0]  o_wa3,
  output logic        o_we3,
  output logic [2:0]  o_ula_control,
  output logic        o_ula_src,
  output logic [7:0]  o_imm,
  input  logic        i_z,
  output logic [7:0]  o_pc,
  output logic [2:0]  o_state,
  output logic        o_halted,
  output logic        o_illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_R    = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic        r_z;
  logic        r_halted;
  logic        r_illegal;

  // Instruction fields
  logic [3:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic [2:0]  w_fn;
  logic [5:0]  w_imm6;
  logic [7:0]  w_tgt;
  logic [7:0]  w_imm;
  logic        w_legal;
  logic        w_fetch_go;
  logic [7:0]  w_pc_inc;
  logic [7:0]  w_pc_nxt;

  assign w_op   = r_ir[15:12];
  assign w_rd   = r_ir[11:9];
  assign w_rs   = r_ir[8:6];
  assign w_rt   = r_ir[5:3];
  assign w_fn   = r_ir[2:0];
  assign w_imm6 = r_ir[5:0];
  assign w_tgt  = r_ir[7:0];
  assign w_imm  = {{2{w_imm6[5]}}, w_imm6};

  assign w_legal = (w_op == OP_NOP) || (w_op == OP_R) || (w_op == OP_ADDI) ||
                   (w_op == OP_BEQ) || (w_op == OP_JMP) || (w_op == HALT_OP);

  // An ack is only honoured while a request is actually being made.
  assign w_fetch_go = (r_state == S_FETCH) && i_run && i_imem_ack;

  assign w_pc_inc = r_pc + 8'd1;

  // Illegal opcodes fall into the default arm and so behave as NOP.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (w_op)
      OP_JMP:  w_pc_nxt = w_tgt;
      OP_BEQ:  w_pc_nxt = r_z ? (w_pc_inc + w_imm) : w_pc_inc;
      default: w_pc_nxt = w_pc_inc;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  w_state_nxt = w_fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: w_state_nxt = (w_op == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Decode outputs come straight from the instruction
  // register, which is stable from DECODE through WB, so they naturally hold
  // their decode values; reset clears the register and hence these outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    // Gate with reset so the request drops immediately even though the
    // reset state (FETCH) would otherwise follow i_run.
    o_imem_req    = (r_state == S_FETCH) && i_run && iRST_N;
    o_we3         = (r_state == S_WB) && ((w_op == OP_R) || (w_op == OP_ADDI));
    o_wa3         = w_rd;
    o_ra1         = (w_op == OP_BEQ) ? w_rd : w_rs;
    o_ra2         = (w_op == OP_BEQ) ? w_rs : w_rt;
    o_imm         = w_imm;
    o_ula_src     = (w_op == OP_ADDI);
    o_ula_control = 3'b000;
    case (w_op)
      OP_R:    o_ula_control = w_fn;
      OP_ADDI: o_ula_control = 3'b010;
      OP_BEQ:  o_ula_control = 3'b110;
      default: o_ula_control = 3'b000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_z       <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_go) begin
            r_ir <= i_imem_data;
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
          end
          if (w_op == HALT_OP) begin
            r_halted <= 1'b1;
          end
        end
        S_EXEC: begin
          r_z <= i_z;
        end
        S_WB: begin
          r_pc <= w_pc_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_state     = r_state;
  assign o_halted    = r_halted;
  assign o_illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer. A driver acts as the
//            instruction memory, pushes the expected write-back view of each
//            instruction into a queue, and a monitor compares it whenever the
//            DUT presents its WB cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic        iCLK;
  logic        iRST_N;
  logic        i_run;
  logic [7:0]  o_imem_addr;
  logic        o_imem_req;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic [2:0]  o_ra1;
  logic [2:0]  o_ra2;
  logic [2:0]  o_wa3;
  logic        o_we3;
  logic [2:0]  o_ula_control;
  logic        o_ula_src;
  logic [7:0]  o_imm;
  logic        i_z;
  logic [7:0]  o_pc;
  logic [2:0]  o_state;
  logic        o_halted;
  logic        o_illegal;

  instr_sequencer #(.RESET_PC(RESET_PC), .HALT_OP(4'hF)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .i_run(i_run),
    .o_imem_addr(o_imem_addr), .o_imem_req(o_imem_req),
    .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .o_ra1(o_ra1), .o_ra2(o_ra2), .o_wa3(o_wa3), .o_we3(o_we3),
    .o_ula_control(o_ula_control), .o_ula_src(o_ula_src), .o_imm(o_imm),
    .i_z(i_z), .o_pc(o_pc), .o_state(o_state),
    .o_halted(o_halted), .o_illegal(o_illegal)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [7:0] pc;
    logic       we;
    logic [2:0] wa3;
    logic       chk_ctl;
    logic [2:0] ctl;
    logic       src;
    logic [7:0] imm;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  logic mon_en   = 1'b0;
  logic [7:0] m_pc;
  logic       m_ill;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: architectural effect of one instruction.
  function automatic int sext6(input logic [15:0] w);
    int v;
    v = int'(w[5:0]);
    if (v >= 32) v = v - 64;
    return v;
  endfunction

  function automatic logic [7:0] model_next_pc(input logic [15:0] w, input logic [7:0] pc, input logic z);
    int n;
    case (w[15:12])
      4'h4:    n = int'(w[7:0]);
      4'h3:    n = z ? (int'(pc) + 1 + sext6(w)) : (int'(pc) + 1);
      default: n = int'(pc) + 1;
    endcase
    n = (n + 512) % 256;
    return n[7:0];
  endfunction

  function automatic exp_t model_wb(input logic [15:0] w, input logic [7:0] pc, input logic ill);
    exp_t e;
    int   s;
    logic [3:0] op;
    op = w[15:12];
    s = sext6(w) & 255;
    e.pc      = pc;
    e.we      = (op == 4'h1) || (op == 4'h2);
    e.wa3     = w[11:9];
    e.chk_ctl = (op == 4'h1) || (op == 4'h2) || (op == 4'h3);
    e.ctl     = (op == 4'h1) ? w[2:0] : (op == 4'h2) ? 3'b010 : 3'b110;
    e.src     = (op == 4'h2);
    e.imm     = s[7:0];
    e.ra1     = (op == 4'h3) ? w[11:9] : w[8:6];
    e.ra2     = (op == 4'h3) ? w[8:6]  : w[5:3];
    e.ill     = ill;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (mon_en) begin
        if (o_state == 3'd3) begin
          if (q.size() == 0) begin
            fail_now("wb_without_instruction");
          end else begin
            e = q.pop_front();
            chk("wb_pc", o_pc, e.pc);
            chk("wb_we3", o_we3, e.we);
            if (e.we) chk("wb_wa3", o_wa3, e.wa3);
            if (e.chk_ctl) begin
              chk("wb_ula_control", o_ula_control, e.ctl);
              chk("wb_ula_src", o_ula_src, e.src);
            end
            chk("wb_imm", o_imm, e.imm);
            chk("wb_ra1", o_ra1, e.ra1);
            chk("wb_ra2", o_ra2, e.ra2);
            chk("wb_illegal", o_illegal, e.ill);
          end
        end else begin
          chk("we3_outside_wb", o_we3, 1'b0);
        end
        if (o_state == 3'd4) begin
          chk("halt_req", o_imem_req, 1'b0);
          chk("halt_flag", o_halted, 1'b1);
        end
      end
    end
  endtask

  // Serve one fetch: wait for FETCH, stall dly cycles, then ack with w.
  task automatic do_fetch(input logic [15:0] w, input logic z, input int dly);
    int n;
    logic [3:0] op;
    n = 0;
    i_run = 1'b1;
    while (o_state != 3'd0 && n < 30) begin
      @(posedge iCLK); #1;
      n++;
    end
    if (o_state != 3'd0) begin
      fail_now("fetch_wait_timeout");
      return;
    end
    for (int k = 0; k < dly; k++) begin
      i_imem_ack = 1'b0;
      chk("stall_req", o_imem_req, 1'b1);
      chk("stall_state", o_state, 3'd0);
      chk("stall_pc", o_pc, m_pc);
      @(posedge iCLK); #1;
    end
    chk("fetch_addr", o_imem_addr, m_pc);
    op = w[15:12];
    i_imem_data = w;
    i_imem_ack  = 1'b1;
    i_z         = z;
    if (op != 4'hF) begin
      if (op > 4'h4) m_ill = 1'b1;
      q.push_back(model_wb(w, m_pc, m_ill));
      m_pc = model_next_pc(w, m_pc, z);
    end
    @(posedge iCLK); #1;
    i_imem_ack  = 1'b0;
    i_imem_data = 16'($urandom);
    chk("decode_entry", o_state, 3'd1);
    // Dropping run mid-instruction must not abort it.
    if ($urandom_range(0, 3) == 0) i_run = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    logic [3:0]  op;
    int sel;
    w = 16'($urandom);
    sel = $urandom_range(0, 6);
    case (sel)
      0: op = 4'h0;
      1: op = 4'h1;
      2: op = 4'h2;
      3: op = 4'h3;
      4: op = 4'h3;
      5: op = 4'h4;
      default: op = 4'($urandom_range(5, 14));
    endcase
    w[15:12] = op;
    return w;
  endfunction

  task automatic run_random(input int count);
    for (int i = 0; i < count; i++) begin
      do_fetch(rand_instr(), 1'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n;
    n = 0;
    while (o_state != s && n < 30) begin
      @(posedge iCLK); #1;
      n++;
    end
    if (o_state != s) fail_now(name);
  endtask

  initial begin
    fork
      monitor();
    join_none

    iRST_N = 1'b0;
    i_run = 1'b1;
    i_imem_ack = 1'b0;
    i_imem_data = 16'h0000;
    i_z = 1'b0;
    m_pc = RESET_PC;
    m_ill = 1'b0;
    #23;
    chk("rst_state", o_state, 3'd0);
    chk("rst_pc", o_pc, RESET_PC);
    chk("rst_req", o_imem_req, 1'b0);
    chk("rst_we3", o_we3, 1'b0);
    chk("rst_imm", o_imm, 8'h00);
    chk("rst_halted", o_halted, 1'b0);
    chk("rst_illegal", o_illegal, 1'b0);

    // Ack without a request is ignored.
    i_run = 1'b0;
    iRST_N = 1'b1;
    i_imem_ack = 1'b1;
    i_imem_data = 16'h4055;
    repeat (3) begin
      @(posedge iCLK); #1;
      chk("noreq_state", o_state, 3'd0);
      chk("noreq_pc", o_pc, RESET_PC);
      chk("noreq_req", o_imem_req, 1'b0);
    end
    i_imem_ack = 1'b0;
    mon_en = 1'b1;

    // Directed sequences.
    do_fetch(16'h2A3F, 1'b0, 0);
    do_fetch(16'h1456, 1'b0, 0);
    do_fetch(16'h3283, 1'b1, 0);
    do_fetch(16'h3283, 1'b0, 3);
    do_fetch(16'h40FF, 1'b0, 1);
    do_fetch(16'h0000, 1'b0, 0);
    do_fetch(16'h7123, 1'b0, 0);
    wait_state(3'd0, "after_directed_timeout");
    chk("wrap_pc", o_pc, 8'h01);
    chk("illegal_sticky", o_illegal, 1'b1);

    run_random(60);

    // Reset during the WB cycle of an ADDI.
    do_fetch(16'h2A3F, 1'b0, 0);
    wait_state(3'd3, "wb_wait_timeout");
    chk("pre_reset_we3", o_we3, 1'b1);
    mon_en = 1'b0;
    #1 iRST_N = 1'b0;
    #1;
    chk("midwb_we3", o_we3, 1'b0);
    chk("midwb_state", o_state, 3'd0);
    chk("midwb_pc", o_pc, RESET_PC);
    chk("midwb_imm", o_imm, 8'h00);
    chk("midwb_ula_src", o_ula_src, 1'b0);
    chk("midwb_wa3", o_wa3, 3'd0);
    chk("midwb_illegal", o_illegal, 1'b0);
    chk("midwb_req", o_imem_req, 1'b0);
    q.delete();
    m_pc = RESET_PC;
    m_ill = 1'b0;
    @(posedge iCLK); #3;
    iRST_N = 1'b1;
    @(posedge iCLK); #1;
    mon_en = 1'b1;

    run_random(15);

    // Halt: frozen for 20 cycles.
    do_fetch(16'hF000, 1'b0, 0);
    i_run = 1'b1;
    @(posedge iCLK); #1;
    repeat (20) begin
      chk("halt_state", o_state, 3'd4);
      chk("halt_pc", o_pc, m_pc);
      chk("halt_req_main", o_imem_req, 1'b0);
      chk("halt_halted", o_halted, 1'b1);
      @(posedge iCLK); #1;
    end
    chk("halt_illegal", o_illegal, m_ill);
    chk("queue_drained", 16'(q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter HALT_OP, default 4'hF: opcode that halts the sequencer.
REQ-003 Port iCLK, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port iRST_N, input, 1: reset, asynchronous and active-low.
REQ-005 Port i_run, input, 1: while high, FETCH may start a new instruction.
REQ-006 Port o_imem_addr, output, 8: instruction memory address, equal to PC.
REQ-007 Port o_imem_req, output, 1: instruction fetch request.
REQ-008 Port i_imem_ack, input, 1: fetch data valid this cycle.
REQ-009 Port i_imem_data, input, 16: instruction word.
REQ-010 Ports o_ra1, o_ra2, o_wa3, output, 3 each: register-file read and write addresses.
REQ-011 Port o_we3, output, 1: register-file write enable.
REQ-012 Port o_ula_control, output, 3: ULA operation select.
REQ-013 Port o_ula_src, output, 1: selects SrcB (0 = rd2, 1 = o_imm).
REQ-014 Port o_imm, output, 8: sign-extended imm6.
REQ-015 Port i_z, input, 1: ULA zero flag.
REQ-016 Port o_pc, output, 8: current PC.
REQ-017 Port o_state, output, 3: current state (FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4).
REQ-018 Ports o_halted and o_illegal, output, 1 each: status flags.

Function
REQ-019 The instruction SHALL be decoded as: op = [15:12], rd = [11:9], rs = [8:6], rt = [5:3], fn = [2:0], imm6 = [5:0], tgt = [7:0].
REQ-020 Opcodes SHALL be:
- 0x0 NOP
- 0x1 R-type: rd = rs fn rt
- 0x2 ADDI: rd = rs + sext(imm6), o_ula_control = 3'b010
- 0x3 BEQ: compare rd with rs, o_ula_control = 3'b110
- 0x4 JMP: PC = tgt
- HALT_OP: halt
- any other opcode: illegal.
REQ-021 FETCH: o_imem_req SHALL equal i_run. When o_imem_req and i_imem_ack are both high, the word SHALL be latched into the instruction register and the state SHALL move to DECODE. Otherwise the state stays in FETCH with PC unchanged.
REQ-022 DECODE (1 cycle):
- o_ra1 = rs and o_ra2 = rt for every opcode except BEQ.
- BEQ: o_ra1 = rd, o_ra2 = rs.
- o_imm = {{2{imm6[5]}}, imm6}.
- Illegal opcode: o_illegal set (sticky until reset) and the instruction is executed as NOP.
REQ-023 EXEC (1 cycle): o_ula_control and o_ula_src SHALL be driven from the decode. R-type: fn and 0. ADDI: 010 and 1. BEQ: 110 and 0. i_z SHALL be sampled at the end of EXEC.
REQ-024 WB (1 cycle):
- o_we3 = 1 only for R-type and ADDI, with o_wa3 = rd; o_we3 = 0 in every other state and case.
- Next PC: JMP gives tgt; BEQ with sampled z = 1 gives PC + 1 + o_imm; otherwise PC + 1.
- All PC arithmetic is modulo 256; wrap 8'hFF to 8'h00 is legal.
REQ-025 After WB the state SHALL return to FETCH. With an immediate ack, each instruction takes 4 cycles.
REQ-026 A HALT_OP fetch SHALL go DECODE then HALT and set o_halted. In HALT, PC is frozen, o_imem_req = 0 and o_we3 = 0; only reset leaves HALT.
REQ-027 i_run falling outside FETCH SHALL NOT abort the instruction in flight.
REQ-028 i_imem_ack while o_imem_req = 0 SHALL be ignored.
REQ-029 o_ra1, o_ra2, o_wa3, o_ula_control, o_ula_src and o_imm SHALL hold their DECODE values through EXEC and WB.

Reset
REQ-030 Asserting iRST_N low at any time, including mid-instruction, SHALL immediately force all of the following:
- state FETCH, PC = RESET_PC, instruction register = 0
- o_imem_req = 0 and o_we3 = 0
- o_ra1 = o_ra2 = o_wa3 = 0, o_ula_control = 0, o_ula_src = 0, o_imm = 0
- o_halted = 0, o_illegal = 0.
REQ-031 After iRST_N deasserts, the first fetch SHALL begin on the first rising edge where i_run = 1.

Verification
REQ-032 ADDI: i_run = 1, ack immediate, PC 0 data 16'h2A3F (rd=5, rs=0, imm6=-1) -> in WB cycle 4: o_imm = 8'hFF, o_ula_src = 1, o_ula_control = 010, o_we3 = 1, o_wa3 = 5; PC = 1.
REQ-033 R-type then BEQ:
- 16'h1456 (rd=2, rs=1, rt=2, fn=6) -> o_ula_control = 110, o_we3 = 1, o_wa3 = 2.
- Then 16'h3283 with i_z = 1 in EXEC at PC 1 -> PC = 5.
- Same BEQ with i_z = 0 -> PC = 2, o_we3 stays 0.
REQ-034 Fetch stall and wrap:
- Ack delayed 3 cycles -> state held in FETCH, o_imem_req held 1, PC unchanged.
- JMP 16'h40FF -> PC = 8'hFF; then NOP -> PC = 8'h00.
REQ-035 Illegal and halt:
- Opcode 0x7 -> o_illegal = 1, o_we3 never asserted, PC + 1.
- Then 16'hF000 -> o_halted = 1 and o_state = 4 for 20 cycles, o_imem_req = 0.
REQ-036 Reset mid-WB: iRST_N low during WB of an ADDI -> o_we3 drops immediately, PC = RESET_PC, o_state = 0.
